uart_fx_framer: RTL and testbench
=================================

# uart_fx_framer

Frame-aware effect router placed between `uart_top` and the audio effect units (hard clipping, bitcrusher, …) in the Colorlight i9 design. It parses `HEADER, MODE, LEN, data…` frames from the UART receiver, sends each data byte through the effect selected by MODE, and buffers the results in a FIFO. It drains that FIFO into the UART transmitter, so back-to-back input is never dropped while TX is busy. It also adds runtime effect selection, an inter-byte timeout, and overflow and abort status.

## Interface
- `DATA_W`, 8: sample/byte width.
- `NUM_FX`, 4: number of effect outputs on `i_fx_bus`.
- `FX_LAT`, 0: cycles from `o_fx_dv` to valid `i_fx_bus`. Range 0..3.
- `FIFO_DEPTH`, 16: output FIFO entries. Must be a power of 2, ≥2.
- `HEADER_BYTE`, 8'hAA: frame sync byte.
- `TIMEOUT_CYC`, 50_000: maximum idle cycles between bytes inside a frame.
- `i_clk`  in  1  system clock (50 MHz).
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx_dv`  in  1  one-cycle pulse, received byte valid.
- `i_rx_byte`  in  DATA_W  received byte.
- `o_fx_dv`  out  1  one-cycle pulse, `o_fx_sample` updated.
- `o_fx_sample`  out  DATA_W  sample presented to all effects.
- `i_fx_bus`  in  NUM_FX*DATA_W  effect outputs; effect k occupies bits [k*DATA_W +: DATA_W].
- `o_tx_dv`  out  1  one-cycle transmit request.
- `o_tx_byte`  out  DATA_W  byte to transmit.
- `i_tx_active`  in  1  transmitter busy.
- `i_tx_done`  in  1  one-cycle pulse, transmission finished.
- `o_frame_active`  out  1  high in the MODE, LEN and DATA states.
- `o_fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `o_overflow_cnt`  out  16  bytes dropped on a full FIFO. Saturates at 16'hFFFF.
- `o_abort`  out  1  one-cycle pulse when a frame is aborted by timeout.

## Operation
- Parser FSM states:
  - WAIT_HEADER: `i_rx_dv` with byte == HEADER_BYTE → GET_MODE. Any other byte is ignored.
  - GET_MODE: on `i_rx_dv`, latch mode → GET_LEN.
  - GET_LEN: on `i_rx_dv`, latch length N. N==0 → WAIT_HEADER. Otherwise load the remaining count = N → DATA.
  - DATA: each `i_rx_dv` is a sample and decrements the remaining count. Reaching 0 → WAIT_HEADER. HEADER_BYTE is ordinary data in this state.
- Effect select: mode < NUM_FX selects `i_fx_bus` slice[mode]. Mode ≥ NUM_FX is bypass: the raw sample is queued. Mode is latched per frame.
- Sample path:
  - A DATA byte is registered into `o_fx_sample` with an `o_fx_dv` pulse.
  - A delay line of FX_LAT registers carries the valid bit and the bypass byte.
  - At the end of the delay line, the selected result is pushed into the FIFO.
- Timeout:
  - An idle counter resets on every `i_rx_dv` and counts only while `o_frame_active`.
  - When it reaches TIMEOUT_CYC, the FSM goes to WAIT_HEADER and `o_abort` pulses.
  - Samples already in flight are still pushed.
- FIFO:
  - Circular buffer with read/write pointers and a level counter; pointers wrap modulo FIFO_DEPTH.
  - A push when level==FIFO_DEPTH is dropped and `o_overflow_cnt`++ (saturating). This holds even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the level unchanged.
- TX drain:
  - A `tx_pending` flag is set on `o_tx_dv` and cleared on `i_tx_done`.
  - When level>0, `!i_tx_active` and `!tx_pending`: pulse `o_tx_dv`, drive `o_tx_byte` = head, pop.
- Reset (asynchronous, any time):
  - FSM → WAIT_HEADER; FIFO emptied; `tx_pending` = 0; pipeline valids cleared.
  - All outputs 0: `o_tx_dv`, `o_tx_byte`, `o_fx_dv`, `o_fx_sample`, `o_frame_active`, `o_fifo_level`, `o_overflow_cnt`, `o_abort`.

## Timing
- `i_rx_dv` at cycle t (DATA state):
  - `o_fx_dv` and `o_fx_sample` at t+1.
  - FIFO push at t+1+FX_LAT.
  - `o_fifo_level` reflects the push at t+2+FX_LAT.
- Empty FIFO with idle TX: `o_tx_dv` at t+2+FX_LAT, i.e. one cycle after the push is visible. The next request comes no earlier than the cycle after `i_tx_done`.
- FSM transition is visible the cycle after the triggering `i_rx_dv`.
- `o_frame_active` drops the cycle after the last data byte or after the timeout.
- `o_abort` pulses in the cycle the FSM re-enters WAIT_HEADER due to timeout.
- One byte per `i_rx_dv`; at most one push and one pop per cycle.

## Test plan
- Frame AA,00,03,10,20,30 with FX_LAT=0 and effect0 = identity+1 → TX sends 11,21,31 in order; `o_frame_active` drops after 30; `o_fifo_level` returns to 0.
- Frame AA,07,02,AA,55 (mode ≥ NUM_FX, HEADER_BYTE in data) → bypass; TX sends AA,55; FSM ends in WAIT_HEADER.
- Hold `i_tx_active` high, send a frame with LEN=20 and FIFO_DEPTH=16 → level 16, `o_overflow_cnt`=4; release → exactly 16 bytes transmitted, first 16 in order.
- AA,01,05,then 2 data bytes, then silence > TIMEOUT_CYC → one `o_abort` pulse; both bytes transmitted; a subsequent AA,01,01,7F is processed normally.
- Length 0: AA,02,00,AA,02,01,40 → nothing queued for the first frame; 40 processed through effect2.
- Assert `i_rst_n` low mid-frame with FIFO level 5 → all outputs 0 immediately; after release, the stale bytes are never transmitted and non-header bytes are ignored.

Source files
------------

// File: rtl/uart_fx_framer_if.sv
// Bundles the UART RX, effect, TX and status signals of the frame-aware
// effect router into one port. The slave modport is the framer side.
// The master modport is the surrounding system.
interface uart_fx_framer_if #(
  parameter int DATA_W     = 8,
  parameter int NUM_FX     = 4,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                     i_rx_dv;
  logic [DATA_W-1:0]        i_rx_byte;
  logic                     o_fx_dv;
  logic [DATA_W-1:0]        o_fx_sample;
  logic [NUM_FX*DATA_W-1:0] i_fx_bus;
  logic                     o_tx_dv;
  logic [DATA_W-1:0]        o_tx_byte;
  logic                     i_tx_active;
  logic                     i_tx_done;
  logic                     o_frame_active;
  logic [LVL_W-1:0]         o_fifo_level;
  logic [15:0]              o_overflow_cnt;
  logic                     o_abort;

  modport slave (
    input  i_rx_dv, i_rx_byte, i_fx_bus, i_tx_active, i_tx_done,
    output o_fx_dv, o_fx_sample, o_tx_dv, o_tx_byte,
           o_frame_active, o_fifo_level, o_overflow_cnt, o_abort
  );

  modport master (
    output i_rx_dv, i_rx_byte, i_fx_bus, i_tx_active, i_tx_done,
    input  o_fx_dv, o_fx_sample, o_tx_dv, o_tx_byte,
           o_frame_active, o_fifo_level, o_overflow_cnt, o_abort
  );
endinterface

// File: rtl/uart_fx_framer.sv
// Frame-aware effect router. It parses HEADER/MODE/LEN/data frames from the
// UART receiver and runs each data byte through the selected effect (or
// bypasses it). Results are queued in a FIFO that drains into the UART
// transmitter one byte per completed transmission.
module uart_fx_framer #(
  parameter int               DATA_W      = 8,
  parameter int               NUM_FX      = 4,
  parameter int               FX_LAT      = 0,
  parameter int               FIFO_DEPTH  = 16,
  parameter logic [DATA_W-1:0] HEADER_BYTE = 8'hAA,
  parameter int               TIMEOUT_CYC = 50_000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  uart_fx_framer_if.slave  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SEL_W = (NUM_FX > 1) ? $clog2(NUM_FX) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_HEADER,
    GET_MODE,
    GET_LEN,
    DATA
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mode;
  logic [DATA_W-1:0] remain;
  logic [CNT_W-1:0]  idle_cnt;
  logic              frame_active;
  logic              abort;
  logic              fx_dv;
  logic [DATA_W-1:0] fx_sample;
  logic [DATA_W-1:0] fx_mode;

  // Frame parser, inter-byte timeout and effect sample register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= WAIT_HEADER;
      mode         <= '0;
      remain       <= '0;
      idle_cnt     <= '0;
      frame_active <= 1'b0;
      abort        <= 1'b0;
      fx_dv        <= 1'b0;
      fx_sample    <= '0;
      fx_mode      <= '0;
    end else begin
      fx_dv <= 1'b0;
      abort <= 1'b0;
      if (bus.i_rx_dv) begin
        idle_cnt <= '0;
        unique case (state)
          WAIT_HEADER: begin
            if (bus.i_rx_byte == HEADER_BYTE) begin
              state        <= GET_MODE;
              frame_active <= 1'b1;
            end
          end
          GET_MODE: begin
            mode  <= bus.i_rx_byte;
            state <= GET_LEN;
          end
          GET_LEN: begin
            if (bus.i_rx_byte == '0) begin
              state        <= WAIT_HEADER;
              frame_active <= 1'b0;
            end else begin
              remain <= bus.i_rx_byte;
              state  <= DATA;
            end
          end
          DATA: begin
            // The mode travels with the sample so a new frame cannot
            // re-route bytes still in the effect delay line.
            fx_dv     <= 1'b1;
            fx_sample <= bus.i_rx_byte;
            fx_mode   <= mode;
            remain    <= remain - DATA_W'(1);
            if (remain == DATA_W'(1)) begin
              state        <= WAIT_HEADER;
              frame_active <= 1'b0;
            end
          end
          default: state <= WAIT_HEADER;
        endcase
      end else if (frame_active) begin
        if (idle_cnt == IDLE_MAX) begin
          idle_cnt     <= '0;
          state        <= WAIT_HEADER;
          frame_active <= 1'b0;
          abort        <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Tap at the end of the effect delay line
  logic              tap_vld;
  logic [DATA_W-1:0] tap_byte;
  logic [DATA_W-1:0] tap_mode;

  generate
    if (FX_LAT == 0) begin : g_no_lat
      assign tap_vld  = fx_dv;
      assign tap_byte = fx_sample;
      assign tap_mode = fx_mode;
    end else begin : g_lat
      logic [FX_LAT-1:0] dl_vld;
      logic [DATA_W-1:0] dl_byte [FX_LAT];
      logic [DATA_W-1:0] dl_mode [FX_LAT];

      // Delay the valid, bypass byte and mode to match effect latency
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          dl_vld <= '0;
        end else begin
          dl_vld[0]  <= fx_dv;
          dl_byte[0] <= fx_sample;
          dl_mode[0] <= fx_mode;
          for (int k = 1; k < FX_LAT; k++) begin
            dl_vld[k]  <= dl_vld[k-1];
            dl_byte[k] <= dl_byte[k-1];
            dl_mode[k] <= dl_mode[k-1];
          end
        end
      end

      assign tap_vld  = dl_vld[FX_LAT-1];
      assign tap_byte = dl_byte[FX_LAT-1];
      assign tap_mode = dl_mode[FX_LAT-1];
    end
  endgenerate

  // Unpack the effect bus into one entry per effect
  logic [DATA_W-1:0] fx_out [NUM_FX];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FX; gi++) begin : g_fx
      assign fx_out[gi] = bus.i_fx_bus[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [SEL_W-1:0]  fx_sel;
  logic [DATA_W-1:0] push_data;
  assign fx_sel    = tap_mode[SEL_W-1:0];
  assign push_data = (tap_mode < DATA_W'(NUM_FX)) ? fx_out[fx_sel] : tap_byte;

  // Output FIFO and TX drain
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [15:0]       overflow_cnt;
  logic              tx_pending;
  logic              push_ok;
  logic              pop;

  // A full FIFO drops the push even if a pop frees a slot this cycle
  assign push_ok = tap_vld && (level != FULL_LVL);
  assign pop     = (level != '0) && !bus.i_tx_active && !tx_pending;

  // FIFO storage write port
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, overflow counter and transmit handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow_cnt <= '0;
      tx_pending   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (tap_vld && (level == FULL_LVL) && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
      if (pop) begin
        tx_pending <= 1'b1;
      end else if (bus.i_tx_done) begin
        tx_pending <= 1'b0;
      end
    end
  end

  assign bus.o_tx_dv        = pop;
  assign bus.o_tx_byte      = pop ? mem[rd_ptr] : '0;
  assign bus.o_fx_dv        = fx_dv;
  assign bus.o_fx_sample    = fx_sample;
  assign bus.o_frame_active = frame_active;
  assign bus.o_fifo_level   = level;
  assign bus.o_overflow_cnt = overflow_cnt;
  assign bus.o_abort        = abort;

endmodule

// File: tb/tb_uart_fx_framer.sv
// Directed bench for uart_fx_framer: frame parsing, effect routing, FIFO
// overflow, timeout abort, zero-length frames and asynchronous reset.
module tb_uart_fx_framer;

  logic clk;
  logic rst_n;
  logic force_busy;
  logic [2:0] tx_cnt;
  logic tx_done;
  int   tests_run;
  int   tests_failed;
  int   abort_cnt;
  logic [7:0] got[$];

  uart_fx_framer_if #(.DATA_W(8), .NUM_FX(4), .FIFO_DEPTH(16)) bus ();

  uart_fx_framer #(
    .DATA_W(8), .NUM_FX(4), .FX_LAT(0), .FIFO_DEPTH(16),
    .HEADER_BYTE(8'hAA), .TIMEOUT_CYC(40)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Effects: 0 = +1, 1 = invert, 2 = shift right, 3 = +3
  assign bus.i_fx_bus = {bus.o_fx_sample + 8'd3, bus.o_fx_sample >> 1,
                         ~bus.o_fx_sample, bus.o_fx_sample + 8'd1};

  // Transmitter model: busy for four cycles, then a done pulse
  assign bus.i_tx_active = force_busy || (tx_cnt != 3'd0);
  assign bus.i_tx_done   = tx_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt  <= 3'd0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (bus.o_tx_dv) begin
        tx_cnt <= 3'd4;
      end else if (tx_cnt != 3'd0) begin
        tx_cnt <= tx_cnt - 3'd1;
        if (tx_cnt == 3'd1) tx_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.o_tx_dv) begin
      got.push_back(bus.o_tx_byte);
      $display("[TB] t=%0t tx byte %h", $time, bus.o_tx_byte);
    end
    if (bus.o_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_dv   = 1'b1;
    bus.i_rx_byte = b;
    @(negedge clk);
    bus.i_rx_dv   = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 2000 && got.size() < n; i++) @(negedge clk);
    check(tag, got.size(), n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    int a0;
    tests_run     = 0;
    tests_failed  = 0;
    abort_cnt     = 0;
    force_busy    = 1'b0;
    rst_n         = 1'b0;
    bus.i_rx_dv   = 1'b0;
    bus.i_rx_byte = 8'h00;

    // Reset state
    idle(3);
    check("rst_tx_dv",   bus.o_tx_dv, 0);
    check("rst_fx",      {bus.o_fx_dv, bus.o_fx_sample}, 0);
    check("rst_status",  {bus.o_frame_active, bus.o_abort, bus.o_fifo_level}, 0);
    check("rst_ovf",     bus.o_overflow_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Frame AA,00,03,10,20,30 through effect 0 (+1) with latency checks
    base = got.size();
    send_byte(8'hAA);
    check("t1_active_after_hdr", bus.o_frame_active, 1);
    send_byte(8'h00);
    send_byte(8'h03);
    @(negedge clk);
    bus.i_rx_dv = 1'b1; bus.i_rx_byte = 8'h10;
    @(negedge clk);
    bus.i_rx_dv = 1'b0;
    check("t1_fx_dv_t1",     bus.o_fx_dv, 1);
    check("t1_fx_sample_t1", bus.o_fx_sample, 8'h10);
    check("t1_level_t1",     bus.o_fifo_level, 0);
    @(negedge clk);
    check("t1_level_t2",     bus.o_fifo_level, 1);
    check("t1_tx_dv_t2",     bus.o_tx_dv, 1);
    check("t1_tx_byte_t2",   bus.o_tx_byte, 8'h11);
    send_byte(8'h20);
    check("t1_active_mid",   bus.o_frame_active, 1);
    send_byte(8'h30);
    check("t1_active_drop",  bus.o_frame_active, 0);
    wait_tx(base + 3, "t1_tx_count");
    check("t1_b0", got[base],   8'h11);
    check("t1_b1", got[base+1], 8'h21);
    check("t1_b2", got[base+2], 8'h31);
    idle(10);
    check("t1_level_end", bus.o_fifo_level, 0);

    // Bypass frame with header byte as data
    base = got.size();
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'h55);
    check("t2_active_drop", bus.o_frame_active, 0);
    send_byte(8'h33);
    check("t2_wait_header", bus.o_frame_active, 0);
    wait_tx(base + 2, "t2_tx_count");
    check("t2_b0", got[base],   8'hAA);
    check("t2_b1", got[base+1], 8'h55);
    idle(20);
    check("t2_no_extra", got.size(), base + 2);

    // Overflow with transmitter held busy
    base = got.size();
    force_busy = 1'b1;
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'd20);
    for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i));
    idle(2);
    check("t3_level_full", bus.o_fifo_level, 16);
    check("t3_overflow",   bus.o_overflow_cnt, 4);
    force_busy = 1'b0;
    wait_tx(base + 16, "t3_tx_count");
    idle(30);
    check("t3_exact_16", got.size(), base + 16);
    for (int i = 0; i < 16; i++) check($sformatf("t3_b%0d", i), got[base+i], 8'h41 + 8'(i));
    check("t3_level_end", bus.o_fifo_level, 0);

    // Timeout abort mid-frame, then a normal frame
    base = got.size();
    a0 = abort_cnt;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h12); send_byte(8'h34);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.o_abort) begin
        seen = 1;
        check("t4_active_at_abort", bus.o_frame_active, 0);
      end
    end
    check("t4_abort_seen", seen, 1);
    idle(20);
    check("t4_abort_once", abort_cnt - a0, 1);
    wait_tx(base + 2, "t4_tx_count");
    check("t4_b0", got[base],   8'hED);
    check("t4_b1", got[base+1], 8'hCB);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01); send_byte(8'h7F);
    wait_tx(base + 3, "t4_tx_count2");
    check("t4_b2", got[base+2], 8'h80);

    // Zero-length frame followed by effect 2 frame
    idle(20);
    base = got.size();
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h00);
    check("t5_len0_idle", bus.o_frame_active, 0);
    idle(3);
    check("t5_len0_level", bus.o_fifo_level, 0);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01); send_byte(8'h40);
    wait_tx(base + 1, "t5_tx_count");
    check("t5_b0", got[base], 8'h20);
    idle(20);
    check("t5_no_extra", got.size(), base + 1);

    // Asynchronous reset mid-frame with five bytes queued
    force_busy = 1'b1;
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i));
    @(negedge clk);
    check("t6_level5", bus.o_fifo_level, 5);
    check("t6_active", bus.o_frame_active, 1);
    base = got.size();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_level",  bus.o_fifo_level, 0);
    check("t6_rst_active", bus.o_frame_active, 0);
    check("t6_rst_ovf",    bus.o_overflow_cnt, 0);
    check("t6_rst_misc",   {bus.o_tx_dv, bus.o_tx_byte, bus.o_fx_dv, bus.o_fx_sample, bus.o_abort}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    force_busy = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
    check("t6_ignored", bus.o_frame_active, 0);
    idle(30);
    check("t6_no_tx",    got.size(), base);
    check("t6_level_end", bus.o_fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
